bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised multi-digit BCD counter with programmable modulus, up/down mode, synchronous load/clear and cascade outputs. It generalises the fixed single-digit decade counter to N packed BCD digits wrapping at an arbitrary modulus (e.g. 60 for minutes/seconds, 24 for hours). It is the building block for clock/timer displays and cascaded counter chains in the counter lab designs.

## Interface
- DIGITS, 2, number of BCD digits; legal range 1..4.
- MODULUS, 60, count range is 0..MODULUS-1; legal range 2..10^DIGITS.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load of din.
- din  input  4*DIGITS  packed BCD load value, digit 0 in bits [3:0].
- en  input  1  count enable (one step per clk when high).
- up  input  1  direction: 1 = increment, 0 = decrement.
- q  output  4*DIGITS  packed BCD count, digit 0 in bits [3:0].
- tc  output  1  combinational terminal count: en & ((up & q==MODULUS-1) | (~up & q==0)).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap-around step.
- load_err  output  1  registered one-cycle pulse, high in the cycle after a rejected load.

## Operation
- Reset (reset=0, async): q=0, wrap=0, load_err=0; held while reset=0. Release is sampled on the next rising clk.
- Per-cycle priority (reset deasserted): clr > load > en > hold.
- clr=1: q<=0; wrap<=0; load_err<=0.
- load=1 (clr=0): if every din digit <=9 and value(din) < MODULUS, q<=din, load_err<=0; otherwise q holds, load_err<=1. wrap<=0.
- en=1 (clr=0, load=0):
  - up=1: q==MODULUS-1 -> q<=0, wrap<=1; else q<=q+1 in BCD (digit 9 -> 0 with carry into next digit).
  - up=0: q==0 -> q<=MODULUS-1 (BCD encoded), wrap<=1; else q<=q-1 in BCD (digit 0 -> 9 with borrow).
  - load_err<=0.
- en=0 and no clr/load: q holds; wrap<=0; load_err<=0.
- q is always a valid BCD value below MODULUS; no state outside that range is reachable after reset.
- Direction change is allowed any cycle; the step taken uses up as sampled at that edge.
- tc lets counters cascade: next stage en = tc of the previous stage, all on the same clk.
- MODULUS-1 BCD constant computed at elaboration; no runtime division.

## Timing
- All state updates on rising clk; reset is the only async path.
- q latency: 1 cycle from clr/load/en sampled to new q.
- tc: zero-latency combinational from q, en, up; valid same cycle.
- wrap and load_err: high exactly 1 cycle, the cycle the corresponding new q is visible; consecutive wraps (e.g. MODULUS=2 held counting) give wrap high on consecutive cycles.
- Reset asserted mid-count: q=0 within the same cycle, no wrap pulse produced; counting restarts from 0 on first enabled edge after release.
- Simultaneous clr+load+en: clr wins, q=0, no flags.
- Simultaneous load+en: load wins, no count step that cycle.

## Test plan
- Reset: DIGITS=2, MODULUS=60, count to 0x37, drop reset between edges -> q=0x00, wrap=0, load_err=0 immediately, before next clk.
- Up wrap: load 0x58, en=1 up=1 for 3 cycles -> q=0x59 (tc=1), 0x00 with wrap=1 one cycle, 0x01 with wrap=0; digit carry 0x09->0x10 checked.
- Down wrap: load 0x01, en=1 up=0 -> q=0x00 (tc=1), then 0x59 with wrap=1; borrow 0x10->0x09 checked.
- Bad loads: q=0x23, load din=0x60 -> q stays 0x23, load_err=1 one cycle; load din=0x1A -> same; load din=0x45 -> q=0x45, load_err=0.
- Priority: q=0x30, assert clr+load(din=0x12)+en same cycle -> q=0x00; then load+en with din=0x12 -> q=0x12, not 0x13.
- Cascade/params: DIGITS=1 MODULUS=10 stage feeding DIGITS=1 MODULUS=6 stage via tc, 60 enabled cycles -> combined 00..59 then both 0, upper wrap pulse once; also DIGITS=2 MODULUS=24 full cycle of 24 steps.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Packed-BCD up/down counter wrapping at MODULUS, with sync clear/load and cascade tc.
// q, wrap and load_err update one clk after the sampled command; tc is combinational; no backpressure.
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] int_to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Largest legal count, fixed at elaboration.
    localparam logic [W-1:0] TOP = int_to_bcd(MODULUS - 1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic           digits_ok;
    logic           load_ok;
    logic           at_top;
    logic           at_zero;
    logic [W-1:0]   q_inc;
    logic [W-1:0]   q_dec;

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    // With every digit valid, packed BCD orders the same as plain binary.
    assign load_ok = digits_ok && (din <= TOP);

    assign at_top  = (q == TOP);
    assign at_zero = (q == '0);
    assign q_inc   = bcd_inc(q);
    assign q_dec   = bcd_dec(q);

    assign tc = en & ((up & at_top) | (~up & at_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if (load_ok) begin
                q        <= din;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
            end
        end else if (en) begin
            load_err <= 1'b0;
            if (up) begin
                q    <= at_top ? '0 : q_inc;
                wrap <= at_top;
            end else begin
                q    <= at_zero ? TOP : q_dec;
                wrap <= at_zero;
            end
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: directed scenarios plus random commands against an integer model.
module tb_bcd_mod_counter;

    logic clk;
    logic reset;

    logic       a_clr, a_load, a_en, a_up;
    logic [7:0] a_din;
    logic [7:0] a_q;
    logic       a_tc, a_wrap, a_err;

    logic       c_en;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c0_wrap, c0_err;
    logic       c1_tc, c1_wrap, c1_err;

    logic       d_en, d_up;
    logic [7:0] d_q;
    logic       d_tc, d_wrap, d_err;

    int checks   = 0;
    int failures = 0;

    int mq;
    bit mw, me;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a (
        .clk(clk), .reset(reset), .clr(a_clr), .load(a_load), .din(a_din),
        .en(a_en), .up(a_up), .q(a_q), .tc(a_tc), .wrap(a_wrap), .load_err(a_err)
    );

    bcd_mod_counter #(.DIGITS(1), .MODULUS(10)) u_c0 (
        .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .din(4'd0),
        .en(c_en), .up(1'b1), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap), .load_err(c0_err)
    );

    bcd_mod_counter #(.DIGITS(1), .MODULUS(6)) u_c1 (
        .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .din(4'd0),
        .en(c0_tc), .up(1'b1), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap), .load_err(c1_err)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_d (
        .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .din(8'd0),
        .en(d_en), .up(d_up), .q(d_q), .tc(d_tc), .wrap(d_wrap), .load_err(d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the 2-digit mod-60 counter and check the same-cycle terminal count.
    task automatic a_set(input bit c, input bit l, input bit e, input bit u, input logic [7:0] d);
        bit exp_tc;
        a_clr  = c;
        a_load = l;
        a_en   = e;
        a_up   = u;
        a_din  = d;
        #1;
        exp_tc = e && (u ? (mq == 59) : (mq == 0));
        check("a_tc", 32'(a_tc), 32'(exp_tc));
    endtask

    // Advance the model by one clock using the driven command, then compare.
    task automatic a_clk();
        logic [15:0] eq;
        if (a_clr) begin
            mq = 0; mw = 0; me = 0;
        end else if (a_load) begin
            mw = 0;
            if (bcd_ok(a_din) && bcd_val(a_din) < 60) begin
                mq = bcd_val(a_din);
                me = 0;
            end else begin
                me = 1;
            end
        end else if (a_en) begin
            me = 0;
            mw = a_up ? (mq == 59) : (mq == 0);
            mq = a_up ? (mq + 1) % 60 : (mq + 59) % 60;
        end else begin
            mw = 0; me = 0;
        end
        @(posedge clk);
        #1;
        eq = to_bcd(mq);
        check("a_q", 32'(a_q), 32'(eq[7:0]));
        check("a_wrap", 32'(a_wrap), 32'(mw));
        check("a_load_err", 32'(a_err), 32'(me));
    endtask

    initial begin
        logic [15:0] eq;
        logic [7:0]  rd;
        int          k;
        int          upper_wraps;
        int          r;

        reset = 1'b0;
        a_clr = 0; a_load = 0; a_en = 0; a_up = 1; a_din = '0;
        c_en = 0; d_en = 0; d_up = 1;
        mq = 0; mw = 0; me = 0;

        #12;
        check("rst_q", 32'(a_q), 32'h00);
        check("rst_wrap", 32'(a_wrap), 32'h0);
        check("rst_load_err", 32'(a_err), 32'h0);
        check("rst_d_q", 32'(d_q), 32'h00);
        reset = 1'b1;

        // Count up to 37, then drop reset between edges.
        a_set(0, 1, 0, 1, 8'h30); a_clk();
        repeat (7) begin a_set(0, 0, 1, 1, 8'h00); a_clk(); end
        check("pre_rst_q", 32'(a_q), 32'h37);
        a_set(0, 0, 1, 1, 8'h00);
        reset = 1'b0;
        #1;
        mq = 0; mw = 0; me = 0;
        check("async_rst_q", 32'(a_q), 32'h00);
        check("async_rst_wrap", 32'(a_wrap), 32'h0);
        check("async_rst_load_err", 32'(a_err), 32'h0);
        @(posedge clk);
        #1;
        check("held_rst_q", 32'(a_q), 32'h00);
        #2;
        reset = 1'b1;
        a_set(0, 0, 1, 1, 8'h00); a_clk();
        check("restart_q", 32'(a_q), 32'h01);

        // Up wrap and digit carry.
        a_set(0, 1, 0, 1, 8'h58); a_clk();
        repeat (3) begin a_set(0, 0, 1, 1, 8'h00); a_clk(); end
        check("up_wrap_end", 32'(a_q), 32'h01);
        a_set(0, 1, 0, 1, 8'h09); a_clk();
        a_set(0, 0, 1, 1, 8'h00); a_clk();
        check("carry_q", 32'(a_q), 32'h10);

        // Down wrap and borrow.
        a_set(0, 1, 0, 0, 8'h01); a_clk();
        repeat (2) begin a_set(0, 0, 1, 0, 8'h00); a_clk(); end
        check("down_wrap_q", 32'(a_q), 32'h59);
        check("down_wrap_pulse", 32'(a_wrap), 32'h1);
        a_set(0, 1, 0, 0, 8'h10); a_clk();
        a_set(0, 0, 1, 0, 8'h00); a_clk();
        check("borrow_q", 32'(a_q), 32'h09);

        // Rejected and accepted loads.
        a_set(0, 1, 0, 1, 8'h23); a_clk();
        a_set(0, 1, 0, 1, 8'h60); a_clk();
        check("bad_load_hold", 32'(a_q), 32'h23);
        check("bad_load_err", 32'(a_err), 32'h1);
        a_set(0, 1, 0, 1, 8'h1A); a_clk();
        a_set(0, 1, 0, 1, 8'h45); a_clk();
        check("good_load_q", 32'(a_q), 32'h45);
        check("good_load_err", 32'(a_err), 32'h0);

        // Priority between clr, load and en.
        a_set(0, 1, 0, 1, 8'h30); a_clk();
        a_set(1, 1, 1, 1, 8'h12); a_clk();
        check("clr_wins", 32'(a_q), 32'h00);
        a_set(0, 1, 1, 1, 8'h12); a_clk();
        check("load_beats_en", 32'(a_q), 32'h12);

        // Random command mix.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                eq = to_bcd(int'($urandom_range(0, 69)));
                rd = eq[7:0];
            end else begin
                rd = 8'($urandom);
            end
            a_set(r == 0, (r >= 1) && (r <= 4), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, rd);
            a_clk();
        end
        a_set(0, 0, 0, 1, 8'h00);

        // Cascade of mod-10 feeding mod-6: 60 steps, both stages from 0.
        upper_wraps = 0;
        c_en = 1'b1;
        for (k = 0; k < 60; ) begin
            #1;
            check("c0_tc", 32'(c0_tc), 32'(k % 10 == 9));
            check("c1_tc", 32'(c1_tc), 32'((k % 10 == 9) && ((k / 10) % 6 == 5)));
            @(posedge clk);
            #1;
            k++;
            check("c0_q", 32'(c0_q), 32'(k % 10));
            check("c1_q", 32'(c1_q), 32'((k / 10) % 6));
            check("c0_wrap", 32'(c0_wrap), 32'(k % 10 == 0));
            check("c1_wrap", 32'(c1_wrap), 32'(k % 60 == 0));
            if (c1_wrap) upper_wraps++;
        end
        c_en = 1'b0;
        check("c1_wrap_count", 32'(upper_wraps), 32'd1);

        // Mod-24 two-digit counter: full cycle up, then two steps down.
        d_up = 1'b1;
        d_en = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            #1;
            check("d_tc_up", 32'(d_tc), 32'(j == 24));
            @(posedge clk);
            #1;
            eq = to_bcd(j % 24);
            check("d_q_up", 32'(d_q), 32'(eq[7:0]));
            check("d_wrap_up", 32'(d_wrap), 32'(j == 24));
        end
        d_up = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            #1;
            check("d_tc_dn", 32'(d_tc), 32'(j == 1));
            @(posedge clk);
            #1;
            eq = to_bcd(24 - j);
            check("d_q_dn", 32'(d_q), 32'(eq[7:0]));
            check("d_wrap_dn", 32'(d_wrap), 32'(j == 1));
        end
        d_en = 1'b0;
        check("d_load_err", 32'(d_err), 32'h0);
        check("c_load_err", 32'(c0_err | c1_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
